playback_scheduler: RTL and testbench

PLAYBACK_SCHEDULER -- requirements
Module: playback_scheduler

---
 rtl/autotune_pkg.sv | 26 ++
 rtl/fill_tracker.sv | 52 +++++
 rtl/playback_scheduler.sv | 157 +++++++++++++++
 tb/tb_playback_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/autotune_pkg.sv
// Shared constants and state encoding for the autotune playback path.
package autotune_pkg;

  // Default sizing for the real-time datapath.
  localparam int DEF_WINDOW_SIZE  = 2048;
  localparam int DEF_MAX_EXTENDED = 2200;
  localparam int DEF_DEPTH        = 2 * DEF_MAX_EXTENDED;
  localparam int DEF_READ_PERIOD  = 2304;
  localparam int DEF_PRIME_LEVEL  = 2200;

  // Scheduler state encoding, kept as plain 2-bit constants so the values
  // seen on state_out match the documented encoding exactly.
  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE     = 2'd0;
  localparam sched_state_t ST_PRIMING  = 2'd1;
  localparam sched_state_t ST_PLAYING  = 2'd2;
  localparam sched_state_t ST_UNDERRUN = 2'd3;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fill_tracker.sv
// Ring-buffer occupancy counter with saturation and sticky overrun flag.
module fill_tracker
  import autotune_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int FW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          clear_flags,
  output logic [FW-1:0] fill,
  output logic          overrun
);

  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic full;
  logic empty;
  logic wr_only;
  logic rd_only;

  assign full    = (fill == FULL);
  assign empty   = (fill == '0);
  assign wr_only = wr_en && !rd_en;
  assign rd_only = rd_en && !wr_en;

  // Occupancy: a write alone grows it unless full, a read alone shrinks it
  // unless empty; a simultaneous write and read cancel out.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fill <= '0;
    end else if (wr_only && !full) begin
      fill <= fill + 1'b1;
    end else if (rd_only && !empty) begin
      fill <= fill - 1'b1;
    end
  end

  // Sticky overrun: a dropped write wins over a same-cycle clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overrun <= 1'b0;
    end else if (wr_only && full) begin
      overrun <= 1'b1;
    end else if (clear_flags) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/playback_scheduler.sv
// Playback scheduler: primes the PSOLA ring buffer, then issues periodic
// read pulses, and tracks the analysis-window sample index.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | playback disabled; writes still counted into fill
//   PRIMING  | waiting for fill to reach PRIME_LEVEL
//   PLAYING  | period counter running, one read every READ_PERIOD cycles
//   UNDERRUN | a read came due with nothing buffered; re-prime next cycle
module playback_scheduler
  import autotune_pkg::*;
#(
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int READ_PERIOD = DEF_READ_PERIOD,
  parameter int PRIME_LEVEL = DEF_PRIME_LEVEL
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           enable_in,
  input  logic                           sample_valid_in,
  input  logic                           psola_valid_in,
  input  logic                           clear_flags_in,
  output logic                           read_trigger_out,
  output logic                           window_start_out,
  output logic [$clog2(WINDOW_SIZE)-1:0] sample_idx_out,
  output logic [$clog2(DEPTH+1)-1:0]     fill_out,
  output logic [1:0]                     state_out,
  output logic                           underrun_out,
  output logic                           overrun_out
);

  localparam int IW = $clog2(WINDOW_SIZE);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = cnt_width(READ_PERIOD);

  localparam logic [IW-1:0] IDX_LAST = IW'(WINDOW_SIZE - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(READ_PERIOD - 1);
  localparam logic [FW-1:0] PRIME    = FW'(PRIME_LEVEL);
  localparam logic [FW-1:0] ONE      = FW'(1);

  sched_state_t  state;
  sched_state_t  state_nxt;
  logic [PW-1:0] per_cnt;
  logic [FW-1:0] fill;
  logic          playing;
  logic          read_due;
  logic          fill_avail;
  logic          trig_nxt;

  fill_tracker #(
    .DEPTH (DEPTH),
    .FW    (FW)
  ) u_fill (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .wr_en       (psola_valid_in),
    .rd_en       (read_trigger_out),
    .clear_flags (clear_flags_in),
    .fill        (fill),
    .overrun     (overrun_out)
  );

  assign fill_out  = fill;
  assign state_out = state;
  assign playing   = (state == ST_PLAYING);
  assign read_due  = playing && (per_cnt == PER_LAST);

  // A read pulse still in flight has not yet been taken off fill, so a fill
  // of one with a pulse already high counts as empty (matters for very
  // short read periods).
  assign fill_avail = (fill != '0) && !((fill == ONE) && read_trigger_out);

  // The read pulse is held off when enable drops so it can never show up
  // in the IDLE cycle that follows.
  assign trig_nxt = read_due && fill_avail && enable_in;

  // Next-state decode; dropping enable overrides every transition.
  always_comb begin
    state_nxt = state;
    if (!enable_in) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     state_nxt = ST_PRIMING;
        ST_PRIMING:  if (fill >= PRIME) state_nxt = ST_PLAYING;
        ST_PLAYING:  if (read_due && !fill_avail) state_nxt = ST_UNDERRUN;
        ST_UNDERRUN: state_nxt = ST_PRIMING;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Period counter: parked at 0 outside PLAYING so every entry starts a
  // fresh period and the first read lands READ_PERIOD cycles later.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      per_cnt <= '0;
    end else if (!playing || (state_nxt != ST_PLAYING)) begin
      per_cnt <= '0;
    end else if (per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // Registered one-cycle read pulse, issued the cycle after the period ends.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      read_trigger_out <= 1'b0;
    end else begin
      read_trigger_out <= trig_nxt;
    end
  end

  // Sticky underrun flag; a same-cycle set beats the clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      underrun_out <= 1'b0;
    end else if (read_due && !fill_avail) begin
      underrun_out <= 1'b1;
    end else if (clear_flags_in) begin
      underrun_out <= 1'b0;
    end
  end

  // Window sample index, independent of scheduler state. It rests at the
  // last index after reset so the first accepted sample lands on 0 and
  // opens a window.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sample_idx_out   <= IDX_LAST;
      window_start_out <= 1'b0;
    end else begin
      window_start_out <= 1'b0;
      if (sample_valid_in) begin
        if (sample_idx_out == IDX_LAST) begin
          sample_idx_out   <= '0;
          window_start_out <= 1'b1;
        end else begin
          sample_idx_out <= sample_idx_out + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_playback_scheduler.sv
// Directed bench for playback_scheduler with a small configuration
// (window 8, depth 8, read period 5, prime level 4).
module tb_playback_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       enable_in;
  logic       sample_valid_in;
  logic       psola_valid_in;
  logic       clear_flags_in;
  logic       read_trigger_out;
  logic       window_start_out;
  logic [2:0] sample_idx_out;
  logic [3:0] fill_out;
  logic [1:0] state_out;
  logic       underrun_out;
  logic       overrun_out;

  int checks = 0;
  int errors = 0;
  int ws_count;
  logic [31:0] exp_fill;

  playback_scheduler #(
    .WINDOW_SIZE (8),
    .DEPTH       (8),
    .READ_PERIOD (5),
    .PRIME_LEVEL (4)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .enable_in        (enable_in),
    .sample_valid_in  (sample_valid_in),
    .psola_valid_in   (psola_valid_in),
    .clear_flags_in   (clear_flags_in),
    .read_trigger_out (read_trigger_out),
    .window_start_out (window_start_out),
    .sample_idx_out   (sample_idx_out),
    .fill_out         (fill_out),
    .state_out        (state_out),
    .underrun_out     (underrun_out),
    .overrun_out      (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},    32'(state_out),        32'd0);
    chk({tag, "_fill"},     32'(fill_out),         32'd0);
    chk({tag, "_idx"},      32'(sample_idx_out),   32'd7);
    chk({tag, "_trig"},     32'(read_trigger_out), 32'd0);
    chk({tag, "_wstart"},   32'(window_start_out), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun_out),     32'd0);
    chk({tag, "_overrun"},  32'(overrun_out),      32'd0);
  endtask

  initial begin
    rst_in          = 1'b1;
    enable_in       = 1'b0;
    sample_valid_in = 1'b0;
    psola_valid_in  = 1'b0;
    clear_flags_in  = 1'b0;

    #2;
    chk_reset_values("reset");
    tick();
    tick();
    rst_in = 1'b0;

    // Enable, prime with 4 writes, first read 5 cycles after PLAYING entry.
    enable_in = 1'b1;
    tick();
    chk("enable_priming", 32'(state_out), 32'd1);
    psola_valid_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("prime_fill", 32'(fill_out), 32'(k));
      chk("prime_state", 32'(state_out), 32'd1);
    end
    psola_valid_in = 1'b0;
    tick();
    chk("entry_playing", 32'(state_out), 32'd2);
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("first_period_no_trig", 32'(read_trigger_out), 32'd0);
    end
    tick();
    chk("first_trig", 32'(read_trigger_out), 32'd1);
    chk("first_trig_fill", 32'(fill_out), 32'd4);
    tick();
    chk("after_first_trig", 32'(read_trigger_out), 32'd0);
    chk("fill_4_to_3", 32'(fill_out), 32'd3);

    // Drain without writes: reads at t=10,15,20 then underrun at t=25.
    for (int t = 7; t <= 24; t++) begin
      tick();
      exp_fill = (t < 11) ? 32'd3 : (t < 16) ? 32'd2 : (t < 21) ? 32'd1 : 32'd0;
      chk("drain_trig", 32'(read_trigger_out), (t % 5 == 0) ? 32'd1 : 32'd0);
      chk("drain_fill", 32'(fill_out), exp_fill);
      chk("drain_state", 32'(state_out), 32'd2);
    end
    tick();
    chk("underrun_state", 32'(state_out), 32'd3);
    chk("underrun_no_trig", 32'(read_trigger_out), 32'd0);
    chk("underrun_flag", 32'(underrun_out), 32'd1);
    tick();
    chk("reprime_state", 32'(state_out), 32'd1);
    chk("underrun_sticky", 32'(underrun_out), 32'd1);
    clear_flags_in = 1'b1;
    tick();
    clear_flags_in = 1'b0;
    chk("underrun_cleared", 32'(underrun_out), 32'd0);

    // Disable, then 9 writes in IDLE: saturate at 8 and flag overrun.
    enable_in = 1'b0;
    tick();
    chk("disable_idle", 32'(state_out), 32'd0);
    psola_valid_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("sat_fill", 32'(fill_out), (k > 8) ? 32'd8 : 32'(k));
      chk("sat_overrun", 32'(overrun_out), (k == 9) ? 32'd1 : 32'd0);
    end
    clear_flags_in = 1'b1;
    tick();
    chk("set_and_clear_keeps_flag", 32'(overrun_out), 32'd1);
    chk("set_and_clear_fill", 32'(fill_out), 32'd8);
    psola_valid_in = 1'b0;
    tick();
    clear_flags_in = 1'b0;
    chk("overrun_cleared", 32'(overrun_out), 32'd0);

    // Re-enable with a full buffer; write coincident with the first read.
    enable_in = 1'b1;
    tick();
    chk("full_priming", 32'(state_out), 32'd1);
    tick();
    chk("full_playing", 32'(state_out), 32'd2);
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("full_no_trig", 32'(read_trigger_out), 32'd0);
    end
    tick();
    chk("full_trig", 32'(read_trigger_out), 32'd1);
    chk("full_trig_fill", 32'(fill_out), 32'd8);
    psola_valid_in = 1'b1;
    tick();
    psola_valid_in = 1'b0;
    chk("wr_rd_fill_stays", 32'(fill_out), 32'd8);
    chk("wr_rd_no_overrun", 32'(overrun_out), 32'd0);

    // 10 samples while PLAYING: index 0..7,0,1 and two window starts.
    chk("idx_rest", 32'(sample_idx_out), 32'd7);
    ws_count = 0;
    sample_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sample_idx", 32'(sample_idx_out), 32'(i % 8));
      chk("window_start", 32'(window_start_out), (i == 0 || i == 8) ? 32'd1 : 32'd0);
      if (window_start_out === 1'b1) ws_count++;
    end
    sample_valid_in = 1'b0;
    tick();
    chk("idx_hold", 32'(sample_idx_out), 32'd1);
    chk("window_start_count", 32'(ws_count), 32'd2);

    // Asynchronous reset between edges while PLAYING.
    chk("pre_reset_state", 32'(state_out), 32'd2);
    #2;
    rst_in = 1'b1;
    #1;
    chk_reset_values("async_reset");
    tick();
    rst_in = 1'b0;
    tick();
    chk("post_reset_playing_cleared", 32'(state_out), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
